// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl_pkg
// Brief    : Shared constants, next-PC select encoding and helpers for fetch.
// Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_ctrl_pkg;

    localparam int c_PC_STEP      = 4;
    localparam int c_ADDR_W_DEF   = 32;
    localparam int c_QDEPTH_DEF   = 4;

    typedef enum logic [1:0] {
        NPC_HOLD     = 2'd0,
        NPC_REDIRECT = 2'd1,
        NPC_PREDICT  = 2'd2,
        NPC_SEQ      = 2'd3
    } npc_sel_t;

    // Pointer width for a power-of-two queue; never narrower than one bit.
    function automatic int qptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl_if
// Brief    : Predictor / ID-resolution / fetch-output bundle for pc_fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              pdt_branch;
    logic              pdt_taken;
    logic [ADDR_W-1:0] pdt_pc;
    logic              id_resolve;
    logic              id_taken;
    logic [ADDR_W-1:0] id_target;

    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              flush;
    logic              upd_valid;
    logic              true_or_not;
    logic              pdt_true;
    logic              stallreq;

    modport master (
        output stall, pdt_branch, pdt_taken, pdt_pc, id_resolve, id_taken, id_target,
        input  pc, ce, flush, upd_valid, true_or_not, pdt_true, stallreq
    );

    modport slave (
        input  stall, pdt_branch, pdt_taken, pdt_pc, id_resolve, id_taken, id_target,
        output pc, ce, flush, upd_valid, true_or_not, pdt_true, stallreq
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl_branch_queue.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl_branch_queue
// Brief    : In-order FIFO of outstanding predictions {pc, taken, target}.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl_branch_queue
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int QDEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_push,
    input  wire logic              i_pop,
    input  wire logic              i_clear,
    input  wire logic [ADDR_W-1:0] i_pc,
    input  wire logic              i_taken,
    input  wire logic [ADDR_W-1:0] i_target,
    output logic      [ADDR_W-1:0] o_head_pc,
    output logic                   o_head_taken,
    output logic      [ADDR_W-1:0] o_head_target,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int c_PTR_W = qptr_w(QDEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic [ADDR_W-1:0]  r_pc_mem  [QDEPTH];
    logic               r_tkn_mem [QDEPTH];
    logic [ADDR_W-1:0]  r_tgt_mem [QDEPTH];

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (c_PTR_W+1)'(QDEPTH));

    // A pop frees the slot a full-queue push needs in the same edge.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    assign o_head_pc     = r_pc_mem[r_rd_ptr];
    assign o_head_taken  = r_tkn_mem[r_rd_ptr];
    assign o_head_target = r_tgt_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_pc_mem[r_wr_ptr]  <= i_pc;
            r_tkn_mem[r_wr_ptr] <= i_taken;
            r_tgt_mem[r_wr_ptr] <= i_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Brief    : IF-stage PC generator with prediction tracking and mispredict recovery.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = c_QDEPTH_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pc_fetch_ctrl_if.slave  fetch_if
);

    localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(c_PC_STEP);

    logic [ADDR_W-1:0] r_pc;
    logic              r_ce;
    logic              r_upd_valid;
    logic              r_true_or_not;
    logic              r_pdt_true;

    logic [ADDR_W-1:0] w_head_pc;
    logic              w_head_taken;
    logic [ADDR_W-1:0] w_head_target;
    logic              w_full;
    logic              w_empty;
    logic              w_resolve;
    logic              w_mispredict;
    logic              w_stallreq;
    logic              w_push;
    npc_sel_t          w_npc_sel;
    logic [ADDR_W-1:0] w_next_pc;

    // Resolutions against an empty queue have nothing to compare and are dropped.
    assign w_resolve    = fetch_if.id_resolve & ~w_empty;
    assign w_mispredict = w_resolve &
                          ((fetch_if.id_taken != w_head_taken) |
                           (fetch_if.id_taken & (fetch_if.id_target != w_head_target)));
    assign w_stallreq   = fetch_if.pdt_branch & w_full & ~fetch_if.id_resolve;
    assign w_push       = r_ce & fetch_if.pdt_branch & ~fetch_if.stall & ~w_mispredict &
                          (~w_full | w_resolve);

    pc_fetch_ctrl_branch_queue #(
        .ADDR_W (ADDR_W),
        .QDEPTH (QDEPTH)
    ) u_branch_queue (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_pop         (w_resolve),
        .i_clear       (w_mispredict),
        .i_pc          (r_pc),
        .i_taken       (fetch_if.pdt_taken),
        .i_target      (fetch_if.pdt_pc),
        .o_head_pc     (w_head_pc),
        .o_head_taken  (w_head_taken),
        .o_head_target (w_head_target),
        .o_full        (w_full),
        .o_empty       (w_empty)
    );

    // First cycle out of reset only raises ce; the fetch address stays RESET_PC.
    always_comb begin
        w_npc_sel = NPC_SEQ;
        if (!r_ce)
            w_npc_sel = NPC_HOLD;
        else if (w_mispredict)
            w_npc_sel = NPC_REDIRECT;
        else if (fetch_if.stall || w_stallreq)
            w_npc_sel = NPC_HOLD;
        else if (fetch_if.pdt_branch && fetch_if.pdt_taken)
            w_npc_sel = NPC_PREDICT;
    end

    always_comb begin
        w_next_pc = r_pc + c_STEP;
        case (w_npc_sel)
            NPC_HOLD:     w_next_pc = r_pc;
            NPC_REDIRECT: w_next_pc = fetch_if.id_taken ? fetch_if.id_target
                                                        : w_head_pc + c_STEP;
            NPC_PREDICT:  w_next_pc = fetch_if.pdt_pc;
            default:      w_next_pc = r_pc + c_STEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_ce <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_valid   <= 1'b0;
            r_true_or_not <= 1'b0;
            r_pdt_true    <= 1'b0;
        end else begin
            r_upd_valid <= w_resolve;
            if (w_resolve) begin
                r_true_or_not <= fetch_if.id_taken;
                r_pdt_true    <= ~w_mispredict;
            end
        end
    end

    assign fetch_if.pc          = r_pc;
    assign fetch_if.ce          = r_ce;
    assign fetch_if.flush       = w_mispredict;
    assign fetch_if.stallreq    = w_stallreq;
    assign fetch_if.upd_valid   = r_upd_valid;
    assign fetch_if.true_or_not = r_true_or_not;
    assign fetch_if.pdt_true    = r_pdt_true;

endmodule
`default_nettype wire
